cache_refill_controller: RTL and testbench

//  Memory-side responder to DirectMappedCache miss signals. On a fetch request it reads one

---
 rtl/cache_refill_controller.sv | 153 +++++++++++++++
 tb/tb_cache_refill_controller.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_controller.sv
// Memory-side refill engine for a direct-mapped cache: writes back a dirty victim line (flush)
// and then fetches the missed line beat-by-beat, handing it to the cache in a single FILL cycle.
module cache_refill_controller #(
    parameter int unsigned BLOCK_SIZE             = 4,
    parameter int unsigned NUM_OF_BLOCKS_PER_LINE = 2,
    parameter int unsigned NUM_OF_CACHE_LINES     = 4,
    parameter int unsigned ADDRESS_SIZE           = 16
) (
    input  logic                                         clk_i,
    input  logic                                         rst_n_i,
    input  logic                                         fetch_req_i,
    input  logic                                         flush_req_i,
    input  logic [ADDRESS_SIZE-1:0]                      miss_address_i,
    input  logic [ADDRESS_SIZE-1:0]                      victim_address_i,
    input  logic [NUM_OF_BLOCKS_PER_LINE*BLOCK_SIZE-1:0] victim_line_i,
    output logic                                         busy_o,
    output logic                                         done_o,
    output logic                                         write_line_o,
    output logic [ADDRESS_SIZE-1:0]                      address_o,
    output logic [NUM_OF_BLOCKS_PER_LINE*BLOCK_SIZE-1:0] line_o,
    output logic                                         mem_valid_o,
    output logic                                         mem_we_o,
    output logic [ADDRESS_SIZE-1:0]                      mem_addr_o,
    output logic [BLOCK_SIZE-1:0]                        mem_wdata_o,
    input  logic [BLOCK_SIZE-1:0]                        mem_rdata_i,
    input  logic                                         mem_ready_i
);

    localparam int unsigned INDEX_LENGTH = $clog2(NUM_OF_CACHE_LINES);
    localparam int unsigned BEAT_W       = $clog2(NUM_OF_BLOCKS_PER_LINE);
    localparam int unsigned LINE_W       = NUM_OF_BLOCKS_PER_LINE * BLOCK_SIZE;
    localparam int unsigned UPPER_W      = ADDRESS_SIZE - BEAT_W;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_OF_BLOCKS_PER_LINE - 1);

    typedef enum logic [1:0] {
        StIdle,
        StFlush,
        StFetch,
        StFill
    } state_e;

    state_e state_q, state_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    // Only {tag, index} is kept; the beat counter supplies the block offset.
    logic [UPPER_W-1:0] miss_upper_q;
    logic [UPPER_W-1:0] victim_upper_q;
    logic [LINE_W-1:0]  victim_line_q;
    logic [LINE_W-1:0]  line_q, line_d;
    logic [ADDRESS_SIZE-1:0] address_q;
    logic [LINE_W-1:0]  line_out_q;
    logic capture_miss, capture_victim, fill_load;

    logic unused_offset_bits;
    assign unused_offset_bits = ^{miss_address_i[BEAT_W-1:0], victim_address_i[BEAT_W-1:0],
                                  INDEX_LENGTH[0]};

    always_comb begin
        state_d        = state_q;
        beat_d         = beat_q;
        line_d         = line_q;
        capture_miss   = 1'b0;
        capture_victim = 1'b0;
        fill_load      = 1'b0;
        busy_o         = (state_q != StIdle);
        done_o         = 1'b0;
        write_line_o   = 1'b0;
        mem_valid_o    = 1'b0;
        mem_we_o       = 1'b0;
        mem_addr_o     = '0;
        mem_wdata_o    = '0;

        unique case (state_q)
            StIdle: begin
                beat_d = '0;
                if (flush_req_i) begin
                    capture_miss   = 1'b1;
                    capture_victim = 1'b1;
                    state_d        = StFlush;
                end else if (fetch_req_i) begin
                    capture_miss = 1'b1;
                    state_d      = StFetch;
                end
            end
            StFlush: begin
                mem_valid_o = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {victim_upper_q, beat_q};
                mem_wdata_o = victim_line_q[beat_q*BLOCK_SIZE +: BLOCK_SIZE];
                if (mem_ready_i) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = StFetch;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            StFetch: begin
                mem_valid_o = 1'b1;
                mem_addr_o  = {miss_upper_q, beat_q};
                if (mem_ready_i) begin
                    line_d[beat_q*BLOCK_SIZE +: BLOCK_SIZE] = mem_rdata_i;
                    if (beat_q == LAST_BEAT) begin
                        beat_d    = '0;
                        fill_load = 1'b1;
                        state_d   = StFill;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            StFill: begin
                write_line_o = 1'b1;
                done_o       = 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q        <= StIdle;
            beat_q         <= '0;
            miss_upper_q   <= '0;
            victim_upper_q <= '0;
            victim_line_q  <= '0;
            line_q         <= '0;
            address_q      <= '0;
            line_out_q     <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            line_q  <= line_d;
            if (capture_miss) begin
                miss_upper_q <= miss_address_i[ADDRESS_SIZE-1:BEAT_W];
            end
            if (capture_victim) begin
                victim_upper_q <= victim_address_i[ADDRESS_SIZE-1:BEAT_W];
                victim_line_q  <= victim_line_i;
            end
            // Cache-facing address/line change only when a fill is presented, then hold.
            if (fill_load) begin
                address_q  <= {miss_upper_q, {BEAT_W{1'b0}}};
                line_out_q <= line_d;
            end
        end
    end

    assign address_o = address_q;
    assign line_o    = line_out_q;

endmodule

// File: tb/tb_cache_refill_controller.sv
// Directed bench for cache_refill_controller (NB=2, BS=4, 16-bit addresses).
module tb_cache_refill_controller;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        fetch_req_i;
    logic        flush_req_i;
    logic [15:0] miss_address_i;
    logic [15:0] victim_address_i;
    logic [7:0]  victim_line_i;
    logic        busy_o;
    logic        done_o;
    logic        write_line_o;
    logic [15:0] address_o;
    logic [7:0]  line_o;
    logic        mem_valid_o;
    logic        mem_we_o;
    logic [15:0] mem_addr_o;
    logic [3:0]  mem_wdata_o;
    logic [3:0]  mem_rdata_i;
    logic        mem_ready_i;

    logic [3:0] rd0, rd1;
    int checks = 0;
    int errors = 0;
    int wl_count = 0;

    cache_refill_controller dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .fetch_req_i      (fetch_req_i),
        .flush_req_i      (flush_req_i),
        .miss_address_i   (miss_address_i),
        .victim_address_i (victim_address_i),
        .victim_line_i    (victim_line_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .write_line_o     (write_line_o),
        .address_o        (address_o),
        .line_o           (line_o),
        .mem_valid_o      (mem_valid_o),
        .mem_we_o         (mem_we_o),
        .mem_addr_o       (mem_addr_o),
        .mem_wdata_o      (mem_wdata_o),
        .mem_rdata_i      (mem_rdata_i),
        .mem_ready_i      (mem_ready_i)
    );

    always #5 clk_i = ~clk_i;

    // Memory returns the block selected by the beat (offset) bit of the request address.
    assign mem_rdata_i = mem_addr_o[0] ? rd1 : rd0;

    always @(posedge clk_i) begin
        if (write_line_o) wl_count <= wl_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; fetches the line at base (offset 0) with `stalls` wait states on beat 0.
    task automatic run_fetch(input logic [15:0] req_addr, input logic [15:0] base,
                             input logic [7:0] exp_line, input int stalls);
        int wl0;
        wl0 = wl_count;
        mem_ready_i    = (stalls == 0);
        fetch_req_i    = 1'b1;
        miss_address_i = req_addr;
        @(negedge clk_i);
        fetch_req_i    = 1'b0;
        miss_address_i = 16'h0;
        check("fetch_busy", busy_o, 1);
        check("fetch_valid0", mem_valid_o, 1);
        check("fetch_we0", mem_we_o, 0);
        check("fetch_addr0", mem_addr_o, base);
        for (int i = 0; i < stalls; i++) begin
            @(negedge clk_i);
            check("stall_valid", mem_valid_o, 1);
            check("stall_addr", mem_addr_o, base);
            check("stall_no_fill", write_line_o, 0);
        end
        mem_ready_i = 1'b1;
        @(negedge clk_i);
        check("fetch_valid1", mem_valid_o, 1);
        check("fetch_addr1", mem_addr_o, base | 16'h1);
        @(negedge clk_i);
        check("fill_write_line", write_line_o, 1);
        check("fill_done", done_o, 1);
        check("fill_address", address_o, base);
        check("fill_line", line_o, exp_line);
        check("fill_no_mem", mem_valid_o, 0);
        @(negedge clk_i);
        check("post_busy", busy_o, 0);
        check("post_write_line", write_line_o, 0);
        check("post_address_hold", address_o, base);
        check("post_line_hold", line_o, exp_line);
        check("one_fill", wl_count, wl0 + 1);
    endtask

    initial begin
        rst_n_i          = 1'b0;
        fetch_req_i      = 1'b0;
        flush_req_i      = 1'b0;
        miss_address_i   = 16'h0;
        victim_address_i = 16'h0;
        victim_line_i    = 8'h0;
        mem_ready_i      = 1'b1;
        rd0              = 4'h5;
        rd1              = 4'hA;

        // 1: reset held while requests toggle
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            fetch_req_i = i[0];
            flush_req_i = ~i[0];
            check("rst_busy", busy_o, 0);
            check("rst_valid", mem_valid_o, 0);
            check("rst_outs", {done_o, write_line_o, mem_we_o}, 0);
            check("rst_addr_line", {address_o, line_o, mem_addr_o, mem_wdata_o}, 0);
        end
        @(negedge clk_i);
        fetch_req_i = 1'b0;
        flush_req_i = 1'b0;
        rst_n_i     = 1'b1;
        @(negedge clk_i);
        check("idle_busy", busy_o, 0);

        // 2: fetch tag=3 at 'h001A (offset bit of the request set, must be ignored)
        run_fetch(16'h001B, 16'h001A, 8'hA5, 0);

        // 3: flush victim 'hC3 @ tag1/idx0, then fetch tag0/idx0
        rd0              = 4'h7;
        rd1              = 4'h9;
        flush_req_i      = 1'b1;
        fetch_req_i      = 1'b1;
        miss_address_i   = 16'h0000;
        victim_address_i = 16'h0008;
        victim_line_i    = 8'hC3;
        @(negedge clk_i);
        flush_req_i      = 1'b0;
        fetch_req_i      = 1'b0;
        victim_address_i = 16'h0;
        victim_line_i    = 8'h0;
        check("wb0_we", {mem_valid_o, mem_we_o}, 2'b11);
        check("wb0_addr", mem_addr_o, 16'h0008);
        check("wb0_data", mem_wdata_o, 4'h3);
        @(negedge clk_i);
        check("wb1_addr", mem_addr_o, 16'h0009);
        check("wb1_data", mem_wdata_o, 4'hC);
        @(negedge clk_i);
        check("rd0_we", {mem_valid_o, mem_we_o}, 2'b10);
        check("rd0_addr", mem_addr_o, 16'h0000);
        @(negedge clk_i);
        check("rd1_addr", mem_addr_o, 16'h0001);
        check("flush_no_early_fill", write_line_o, 0);
        @(negedge clk_i);
        check("flush_fill", write_line_o, 1);
        check("flush_fill_addr", address_o, 16'h0000);
        check("flush_fill_line", line_o, 8'h97);
        @(negedge clk_i);
        check("flush_idle", busy_o, 0);

        // 4: three wait states on beat 0
        rd0 = 4'h5;
        rd1 = 4'hA;
        run_fetch(16'h001A, 16'h001A, 8'hA5, 3);

        // 5: a second fetch pulse while busy is ignored
        begin
            int wl0;
            wl0            = wl_count;
            fetch_req_i    = 1'b1;
            miss_address_i = 16'h0020;
            @(negedge clk_i);
            miss_address_i = 16'h0030;
            @(negedge clk_i);
            fetch_req_i    = 1'b0;
            check("busy_ignore_addr", mem_addr_o, 16'h0021);
            repeat (4) @(negedge clk_i);
            check("busy_ignore_count", wl_count, wl0 + 1);
            check("busy_ignore_fill_addr", address_o, 16'h0020);
            check("busy_ignore_idle", {busy_o, mem_valid_o}, 0);
        end

        // 6: reset during fetch beat 1 aborts the transfer
        begin
            int wl0;
            wl0            = wl_count;
            fetch_req_i    = 1'b1;
            miss_address_i = 16'h001A;
            @(negedge clk_i);
            fetch_req_i    = 1'b0;
            @(negedge clk_i);
            check("abort_beat1", mem_addr_o, 16'h001B);
            rst_n_i = 1'b0;
            #1;
            check("abort_outs", {busy_o, mem_valid_o, write_line_o, done_o}, 0);
            check("abort_addr_line", {address_o, line_o}, 0);
            repeat (2) @(negedge clk_i);
            rst_n_i = 1'b1;
            @(negedge clk_i);
            check("abort_no_fill", wl_count, wl0);
            run_fetch(16'h001A, 16'h001A, 8'hA5, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
